// File: rtl/demux_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
//   Shared definitions for the registered 1-to-4 demultiplexer.
//   - LANE_1..LANE_4 : 2-bit lane select encodings ({s1,s0} and ptr values)
//   - NUM_LANES      : number of output lanes
//   - DEFAULT_WIDTH  : default data width of the input word and each lane
//   - target_lane()  : picks the lane addressed this cycle
// -----------------------------------------------------------------------------
package demux_pkg;

   localparam int unsigned NUM_LANES     = 4;
   localparam int unsigned DEFAULT_WIDTH = 8;

   localparam logic [1:0] LANE_1 = 2'b00;
   localparam logic [1:0] LANE_2 = 2'b01;
   localparam logic [1:0] LANE_3 = 2'b10;
   localparam logic [1:0] LANE_4 = 2'b11;

   // Round-robin mode uses the pointer; select mode uses {s1,s0}.
   // Both encodings share the LANE_x values, so no translation is needed.
   function automatic logic [1:0] target_lane(
      input logic       rr_mode,
      input logic [1:0] ptr,
      input logic       s1,
      input logic       s0
   );
      logic [1:0] lane;
      lane = rr_mode ? ptr : {s1, s0};
      return lane;
   endfunction

endpackage : demux_pkg

// File: rtl/demux_lane_reg.sv
// -----------------------------------------------------------------------------
// demux_lane_reg
//   One-entry output register for a single demux lane.
//
//   Ports
//     clk         : clock, rising edge
//     rst         : asynchronous active-high reset (clears data and valid)
//     load_i      : write data_i into the register this cycle
//     data_i      : word to load
//     out_ready_i : lane consumer takes the held word this cycle
//     data_o      : held word (keeps its last value after delivery)
//     valid_o     : register holds an undelivered word
//     ready_o     : register is empty or draining this cycle
//
//   Handshake: a word leaves when valid_o & out_ready_i at a rising edge.
//   The parent only raises load_i while ready_o is high, so a held word is
//   never overwritten before delivery. Load and delivery in the same cycle
//   replace the word with no bubble.
// -----------------------------------------------------------------------------
module demux_lane_reg #(
   parameter int unsigned WIDTH = demux_pkg::DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o,
   output logic             ready_o
);

   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;
   logic             valid_q;
   logic             valid_d;

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      // Delivery empties the register; a load in the same cycle refills it.
      if (valid_q && out_ready_i) begin
         valid_d = 1'b0;
      end
      if (load_i) begin
         data_d  = data_i;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;
   assign ready_o = (~valid_q) | out_ready_i;

endmodule : demux_lane_reg

// File: rtl/demux_1to4_reg.sv
// -----------------------------------------------------------------------------
// demux_1to4_reg
//   Registered 1-to-4 demultiplexer with per-lane backpressure and an
//   optional round-robin distribution mode.
//
//   Ports
//     clk                       : clock, rising edge
//     rst                       : asynchronous active-high reset
//     in_data  [WIDTH-1:0]      : input word
//     in_valid                  : in_data offered this cycle
//     in_ready                  : target lane can take a word this cycle
//     s1, s0                    : lane select (select mode), {s1,s0} = lane-1
//     rr_mode                   : 1 = round-robin via ptr, 0 = select mode
//     out_1..out_4              : lane data registers
//     out_valid_1..out_valid_4  : lane holds an undelivered word
//     out_ready_1..out_ready_4  : lane consumer takes the word this cycle
//     ptr_dbg  [1:0]            : current round-robin pointer (observability)
//
//   Handshake: a transfer happens on a rising edge where valid & ready are
//   both high, on the input side and independently on each lane. in_ready
//   depends only on the target lane's state and its out_ready, never on
//   in_valid, so a producer may wait for in_ready before raising in_valid.
// -----------------------------------------------------------------------------
module demux_1to4_reg
   import demux_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             s1,
   input  logic             s0,
   input  logic             rr_mode,
   output logic [WIDTH-1:0] out_1,
   output logic [WIDTH-1:0] out_2,
   output logic [WIDTH-1:0] out_3,
   output logic [WIDTH-1:0] out_4,
   output logic             out_valid_1,
   output logic             out_valid_2,
   output logic             out_valid_3,
   output logic             out_valid_4,
   input  logic             out_ready_1,
   input  logic             out_ready_2,
   input  logic             out_ready_3,
   input  logic             out_ready_4,
   output logic [1:0]       ptr_dbg
);

   logic [1:0]           target;
   logic                 accept;
   logic [NUM_LANES-1:0] lane_load;
   logic [NUM_LANES-1:0] lane_valid;
   logic [NUM_LANES-1:0] lane_ready;
   logic [NUM_LANES-1:0] lane_out_ready;
   logic [WIDTH-1:0]     lane_data [NUM_LANES];

   logic [1:0]           ptr_q;
   logic [1:0]           ptr_d;

   assign lane_out_ready = {out_ready_4, out_ready_3, out_ready_2, out_ready_1};

   // Target is recomputed every cycle from the live select inputs; nothing
   // about the destination is captured before the word is accepted.
   assign target = target_lane(rr_mode, ptr_q, s1, s0);

   // Only the target lane is considered: in round-robin mode a full,
   // non-draining lane stalls the input rather than skipping ahead.
   assign in_ready = lane_ready[target];
   assign accept   = in_valid & in_ready;

   always_comb begin
      lane_load = '0;
      if (accept) begin
         case (target)
            LANE_1:  lane_load = 4'b0001;
            LANE_2:  lane_load = 4'b0010;
            LANE_3:  lane_load = 4'b0100;
            LANE_4:  lane_load = 4'b1000;
            default: lane_load = '0;
         endcase
      end
   end

   // The pointer advances only on round-robin accepts; switching rr_mode
   // leaves it untouched so distribution resumes where it stopped.
   always_comb begin
      ptr_d = ptr_q;
      if (accept && rr_mode) begin
         ptr_d = ptr_q + 2'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= LANE_1;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      demux_lane_reg #(
         .WIDTH (WIDTH)
      ) u_lane (
         .clk         (clk),
         .rst         (rst),
         .load_i      (lane_load[k]),
         .data_i      (in_data),
         .out_ready_i (lane_out_ready[k]),
         .data_o      (lane_data[k]),
         .valid_o     (lane_valid[k]),
         .ready_o     (lane_ready[k])
      );
   end

   assign out_1       = lane_data[0];
   assign out_2       = lane_data[1];
   assign out_3       = lane_data[2];
   assign out_4       = lane_data[3];
   assign out_valid_1 = lane_valid[0];
   assign out_valid_2 = lane_valid[1];
   assign out_valid_3 = lane_valid[2];
   assign out_valid_4 = lane_valid[3];
   assign ptr_dbg     = ptr_q;

endmodule : demux_1to4_reg

// File: tb/tb_demux_1to4_reg.sv
// -----------------------------------------------------------------------------
// tb_demux_1to4_reg
//   Self-checking bench for demux_1to4_reg. Inputs change 2 time units after
//   each rising edge; outputs are compared on the falling edge against a
//   lane-array model plus per-lane expected-delivery queues.
// -----------------------------------------------------------------------------
module tb_demux_1to4_reg;

   localparam int W = 8;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [W-1:0] in_data  = '0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic         s1 = 1'b0;
   logic         s0 = 1'b0;
   logic         rr_mode = 1'b0;
   logic [3:0]   ordy = 4'b0000;
   logic [W-1:0] out_1, out_2, out_3, out_4;
   logic         out_valid_1, out_valid_2, out_valid_3, out_valid_4;
   logic [1:0]   ptr_dbg;

   demux_1to4_reg #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .s1          (s1),
      .s0          (s0),
      .rr_mode     (rr_mode),
      .out_1       (out_1),
      .out_2       (out_2),
      .out_3       (out_3),
      .out_4       (out_4),
      .out_valid_1 (out_valid_1),
      .out_valid_2 (out_valid_2),
      .out_valid_3 (out_valid_3),
      .out_valid_4 (out_valid_4),
      .out_ready_1 (ordy[0]),
      .out_ready_2 (ordy[1]),
      .out_ready_3 (ordy[2]),
      .out_ready_4 (ordy[3]),
      .ptr_dbg     (ptr_dbg)
   );

   logic [3:0]   vld;
   logic [W-1:0] dout [4];
   assign vld = {out_valid_4, out_valid_3, out_valid_2, out_valid_1};
   always_comb begin
      dout[0] = out_1;
      dout[1] = out_2;
      dout[2] = out_3;
      dout[3] = out_4;
   end

   // ---------------- scoreboard bookkeeping ----------------
   int pass_cnt  = 0;
   int total_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   logic [W-1:0] m_data  [4] = '{default: '0};
   bit           m_valid [4] = '{default: 1'b0};
   int           m_ptr = 0;
   logic [W-1:0] exp_q [4][$];

   function automatic int model_target();
      return rr_mode ? m_ptr : (2 * int'(s1) + int'(s0));
   endfunction

   function automatic bit model_ready();
      int t;
      t = model_target();
      return !m_valid[t] || ordy[t];
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 4; k++) begin
            m_data[k]  = '0;
            m_valid[k] = 1'b0;
            exp_q[k].delete();
         end
         m_ptr = 0;
      end else begin
         int  t;
         bit  acc;
         t   = model_target();
         acc = in_valid && model_ready();
         for (int k = 0; k < 4; k++)
            if (m_valid[k] && ordy[k]) m_valid[k] = 1'b0;
         if (acc) begin
            m_data[t]  = in_data;
            m_valid[t] = 1'b1;
            exp_q[t].push_back(in_data);
            if (rr_mode) m_ptr = (m_ptr + 1) % 4;
         end
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      check("in_ready", in_ready, model_ready());
      check("ptr", ptr_dbg, m_ptr);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("valid_%0d", k + 1), vld[k], m_valid[k]);
         check($sformatf("data_%0d", k + 1), dout[k], m_data[k]);
         // A delivery takes place at the coming edge: it must be the oldest
         // word accepted for this lane.
         if (vld[k] && ordy[k]) begin
            check($sformatf("deliver_pending_%0d", k + 1), exp_q[k].size() != 0, 1);
            if (exp_q[k].size() != 0)
               check($sformatf("deliver_word_%0d", k + 1), dout[k], exp_q[k].pop_front());
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic drive(input bit v, input logic [W-1:0] d, input logic [1:0] sel,
                        input bit rr, input logic [3:0] r);
      in_valid = v;
      in_data  = d;
      {s1, s0} = sel;
      rr_mode  = rr;
      ordy     = r;
   endtask

   // ---------------- directed stimulus ----------------
   int lane_seq [5] = '{0, 1, 2, 3, 0};

   initial begin
      // Reset state, checked while rst is held
      #3;
      check("rst_valid", vld, 4'b0000);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_3", out_3, 8'h00);
      check("rst_ptr", ptr_dbg, 2'd0);
      step();
      rst = 1'b0;

      // Select mode: A5 to lane 3
      drive(1, 8'hA5, 2'b10, 0, 4'b0000);
      step();
      drive(0, 8'h00, 2'b10, 0, 4'b0000);
      check("sel_out_3", out_3, 8'hA5);
      check("sel_valid", vld, 4'b0100);

      // Backpressure on lane 3, then redirect to lane 1
      drive(1, 8'h5A, 2'b10, 0, 4'b0000);
      #1 check("bp_in_ready", in_ready, 0);
      step();
      check("bp_out_3_held", out_3, 8'hA5);
      drive(1, 8'h5A, 2'b00, 0, 4'b0000);
      #1 check("redir_in_ready", in_ready, 1);
      step();
      drive(0, 8'h00, 2'b00, 0, 4'b0000);
      check("redir_out_1", out_1, 8'h5A);
      check("redir_valid", vld, 4'b0101);

      // Same-cycle drain and refill on lane 2
      drive(1, 8'h11, 2'b01, 0, 4'b0000);
      step();
      check("fill_out_2", out_2, 8'h11);
      drive(1, 8'h22, 2'b01, 0, 4'b0010);
      #1 check("refill_in_ready", in_ready, 1);
      step();
      drive(0, 8'h00, 2'b01, 0, 4'b0000);
      check("refill_out_2", out_2, 8'h22);
      check("refill_valid_2", vld[1], 1);

      // Drain everything, then round-robin wrap
      drive(0, 8'h00, 2'b00, 0, 4'b1111);
      step();
      check("drained_valid", vld, 4'b0000);
      for (int i = 0; i < 5; i++) begin
         drive(1, W'(i + 1), 2'b00, 1, 4'b1111);
         step();
         check($sformatf("rr_word_%0d", i + 1), dout[lane_seq[i]], i + 1);
         check($sformatf("rr_onehot_%0d", i + 1), vld, 4'b0001 << lane_seq[i]);
      end
      drive(0, 8'h00, 2'b00, 1, 4'b1111);
      check("rr_ptr_after_wrap", ptr_dbg, 2'd1);

      // Select-mode accept must leave ptr alone; rr resumes at lane 2
      drive(1, 8'h44, 2'b11, 0, 4'b0000);
      step();
      check("sel_ptr_hold", ptr_dbg, 2'd1);
      drive(1, 8'h66, 2'b00, 1, 4'b0000);
      step();
      drive(0, 8'h00, 2'b00, 1, 4'b0000);
      check("rr_resume_out_2", out_2, 8'h66);
      check("rr_resume_ptr", ptr_dbg, 2'd2);

      // Mixed traffic; the model checks every cycle
      for (int i = 0; i < 40; i++) begin
         drive(1'($urandom_range(0, 1)), W'($urandom_range(0, 255)),
               2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 15)));
         step();
      end

      // Reset mid-stream with lanes 1, 2 valid and ptr = 2
      drive(0, 8'h00, 2'b00, 0, 4'b0000);
      rst = 1'b1;
      step();
      rst = 1'b0;
      drive(1, 8'h31, 2'b00, 1, 4'b0000);
      step();
      drive(1, 8'h32, 2'b00, 1, 4'b0000);
      step();
      drive(0, 8'h00, 2'b00, 1, 4'b0000);
      check("pre_rst_valid", vld, 4'b0011);
      check("pre_rst_ptr", ptr_dbg, 2'd2);
      #1 rst = 1'b1;
      #1;
      check("midrst_valid", vld, 4'b0000);
      check("midrst_out_1", out_1, 8'h00);
      check("midrst_out_2", out_2, 8'h00);
      check("midrst_ptr", ptr_dbg, 2'd0);
      check("midrst_in_ready", in_ready, 1);
      step();
      rst = 1'b0;
      drive(1, 8'h77, 2'b11, 1, 4'b0000);
      step();
      drive(0, 8'h00, 2'b00, 1, 4'b0000);
      check("post_rst_out_1", out_1, 8'h77);
      check("post_rst_valid", vld, 4'b0001);
      step();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule : tb_demux_1to4_reg
